// File: rtl/bf_pkg.sv
// Shared BF machine definitions: opcodes, loader error codes, loader states
// and default program-memory geometry.
package bf_pkg;

  localparam int unsigned PMAW_DEF = 8;
  localparam int unsigned OPW_DEF  = 4;

  localparam logic [3:0] OP_HALT = 4'd0;
  localparam logic [3:0] OP_INCP = 4'd1;
  localparam logic [3:0] OP_DECP = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_OUT  = 4'd5;
  localparam logic [3:0] OP_IN   = 4'd6;
  localparam logic [3:0] OP_JMPF = 4'd7;
  localparam logic [3:0] OP_JMPB = 4'd8;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_UNBAL = 2'd2;
  localparam logic [1:0] ERR_FULL  = 2'd3;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_TERM,
    LD_DONE,
    LD_ERROR
  } loadState_t;

endpackage

// File: rtl/bf_char_decode.sv
// Combinational ASCII to BF opcode decoder. Non-command, non-NUL characters
// are comments (isCmd=0, isNul=0).
module bf_char_decode
  import bf_pkg::*;
#(
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic [7:0]     asciiChar,
  output logic           isCmd,
  output logic           isNul,
  output logic [OPW-1:0] opcode
);

  // Map command characters to opcodes; everything else is not a command
  always_comb begin
    isCmd  = 1'b1;
    isNul  = (asciiChar == 8'h00);
    opcode = OPW'(OP_HALT);
    case (asciiChar)
      8'h3E:   opcode = OPW'(OP_INCP); // >
      8'h3C:   opcode = OPW'(OP_DECP); // <
      8'h2B:   opcode = OPW'(OP_INC);  // +
      8'h2D:   opcode = OPW'(OP_DEC);  // -
      8'h2E:   opcode = OPW'(OP_OUT);  // .
      8'h2C:   opcode = OPW'(OP_IN);   // ,
      8'h5B:   opcode = OPW'(OP_JMPF); // [
      8'h5D:   opcode = OPW'(OP_JMPB); // ]
      default: isCmd  = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// BF program-memory writer: encodes a character stream into opcodes, writes
// them from address 0 and terminates with HALT, raising PMInputDone.
// Define BF_LOADER_CHECK_EN to enable bracket-balance checking.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int unsigned PMAW = PMAW_DEF,
  parameter int unsigned OPW  = OPW_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            char_valid,
  input  logic [7:0]      char_in,
  output logic            char_ready,
  input  logic            end_load,
  output logic [PMAW-1:0] pm_address,
  output logic [OPW-1:0]  pm_data,
  output logic            pm_wren,
  output logic            PMInputDone,
  output logic            load_error,
  output logic [1:0]      error_code,
  output logic [PMAW-1:0] prog_len
);

  loadState_t      state, stateNext;
  logic [PMAW-1:0] wrPtr;
  logic            isCmd, isNul;
  logic [OPW-1:0]  decOp;
  logic            accept, termReq;
  logic            doWrite, incPtr, setErr, clearAll;
  logic [OPW-1:0]  wrOp;
  logic [1:0]      errNext;
`ifdef BF_LOADER_CHECK_EN
  logic [PMAW-1:0] depth;
  logic            depthInc, depthDec;
`endif

  bf_char_decode #(.OPW(OPW)) uDecode (
    .asciiChar (char_in),
    .isCmd     (isCmd),
    .isNul     (isNul),
    .opcode    (decOp)
  );

  assign char_ready  = (state == LD_LOAD) & ~end_load;
  assign accept      = char_valid & char_ready;
  assign termReq     = end_load | (accept & isNul);
  assign PMInputDone = (state == LD_DONE);
  assign load_error  = (state == LD_ERROR);
  // Only commands advance wrPtr, so it doubles as the command count
  assign prog_len    = wrPtr;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= LD_IDLE;
    else        state <= stateNext;
  end

  // Next-state and write/error decisions
  always_comb begin
    stateNext = state;
    doWrite   = 1'b0;
    wrOp      = OPW'(OP_HALT);
    incPtr    = 1'b0;
    setErr    = 1'b0;
    errNext   = ERR_NONE;
    clearAll  = 1'b0;
`ifdef BF_LOADER_CHECK_EN
    depthInc  = 1'b0;
    depthDec  = 1'b0;
`endif
    if (start) begin
      clearAll  = 1'b1;
      stateNext = LD_LOAD;
    end else begin
      case (state)
        LD_LOAD: begin
          if (termReq) begin
`ifdef BF_LOADER_CHECK_EN
            if (depth != '0) begin
              setErr    = 1'b1;
              errNext   = ERR_UNBAL;
              stateNext = LD_ERROR;
            end else begin
              doWrite   = 1'b1;
              stateNext = LD_TERM;
            end
`else
            doWrite   = 1'b1;
            stateNext = LD_TERM;
`endif
          end else if (accept && isCmd) begin
`ifdef BF_LOADER_CHECK_EN
            if (decOp == OPW'(OP_JMPB) && depth == '0) begin
              setErr    = 1'b1;
              errNext   = ERR_UNDER;
              stateNext = LD_ERROR;
            end else
`endif
            if (wrPtr == '1) begin
              setErr    = 1'b1;
              errNext   = ERR_FULL;
              stateNext = LD_ERROR;
            end else begin
              doWrite = 1'b1;
              wrOp    = decOp;
              incPtr  = 1'b1;
`ifdef BF_LOADER_CHECK_EN
              depthInc = (decOp == OPW'(OP_JMPF));
              depthDec = (decOp == OPW'(OP_JMPB));
`endif
            end
          end
        end
        LD_TERM: stateNext = LD_DONE;
        default: stateNext = state;
      endcase
    end
  end

  // Write port, write pointer and error code registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pm_wren    <= 1'b0;
      pm_address <= '0;
      pm_data    <= '0;
      wrPtr      <= '0;
      error_code <= ERR_NONE;
    end else begin
      pm_wren <= doWrite;
      if (doWrite) begin
        pm_address <= wrPtr;
        pm_data    <= wrOp;
      end
      if (clearAll) begin
        wrPtr      <= '0;
        error_code <= ERR_NONE;
      end else begin
        if (incPtr) wrPtr <= wrPtr + 1'b1;
        if (setErr) error_code <= errNext;
      end
    end
  end

`ifdef BF_LOADER_CHECK_EN
  // Bracket nesting depth
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        depth <= '0;
    else if (clearAll) depth <= '0;
    else if (depthInc) depth <= depth + 1'b1;
    else if (depthDec) depth <= depth - 1'b1;
  end
`endif

endmodule

// File: tb/tb_bf_program_loader.sv
// Scoreboard bench for bf_program_loader (PMAW=4 instance so memory-full is
// reachable in a short stream).
module tb_bf_program_loader;

  localparam int TB_PMAW = 4;
  localparam int TB_OPW  = 4;
  localparam int CAP     = (1 << TB_PMAW) - 1;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               char_valid = 1'b0;
  logic [7:0]         char_in = 8'h00;
  logic               char_ready;
  logic               end_load = 1'b0;
  logic [TB_PMAW-1:0] pm_address;
  logic [TB_OPW-1:0]  pm_data;
  logic               pm_wren;
  logic               PMInputDone;
  logic               load_error;
  logic [1:0]         error_code;
  logic [TB_PMAW-1:0] prog_len;

  typedef struct {
    int addr;
    int data;
  } wrExp_t;

  wrExp_t sbQ[$];
  int     passCnt  = 0;
  int     totalCnt = 0;
  int     tbPtr    = 0;

  bf_program_loader #(.PMAW(TB_PMAW), .OPW(TB_OPW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .char_valid  (char_valid),
    .char_in     (char_in),
    .char_ready  (char_ready),
    .end_load    (end_load),
    .pm_address  (pm_address),
    .pm_data     (pm_data),
    .pm_wren     (pm_wren),
    .PMInputDone (PMInputDone),
    .load_error  (load_error),
    .error_code  (error_code),
    .prog_len    (prog_len)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input int obs, input int exp);
    totalCnt++;
    if (obs == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int tbOpcode(input logic [7:0] c);
    case (c)
      ">": return 1;
      "<": return 2;
      "+": return 3;
      "-": return 4;
      ".": return 5;
      ",": return 6;
      "[": return 7;
      "]": return 8;
      8'h00: return 0;
      default: return -1;
    endcase
  endfunction

  // Every observed write must match the oldest expected write
  always @(negedge clock) begin
    if (reset && pm_wren) begin
      if (sbQ.size() == 0) begin
        checkVal("unexpWrite", 1, 0);
      end else begin
        wrExp_t e;
        e = sbQ.pop_front();
        checkVal("wrAddr", int'(pm_address), e.addr);
        checkVal("wrData", int'(pm_data), e.data);
      end
    end
  end

  // Present one character, wait (bounded) for acceptance, push expected write
  task automatic sendChar(input logic [7:0] c, input bit expWrite);
    int     op;
    bit     got;
    wrExp_t e;
    op  = tbOpcode(c);
    got = 1'b0;
    char_in    = c;
    char_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (char_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkVal("readyTimeout", 0, 1);
    if (got && expWrite && op >= 0) begin
      e.addr = tbPtr;
      e.data = op;
      sbQ.push_back(e);
      if (c != 8'h00) tbPtr++;
    end
    @(posedge clock);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendChar(s[i], 1'b1);
  endtask

  task automatic startLoad();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    tbPtr = 0;
    checkVal("lenAfterStart", int'(prog_len), 0);
    checkVal("readyAfterStart", int'(char_ready), 1);
  endtask

  task automatic checkDrained(input string tag);
    repeat (2) @(negedge clock);
    checkVal(tag, sbQ.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_wren"}, int'(pm_wren), 0);
    checkVal({tag, "_addr"}, int'(pm_address), 0);
    checkVal({tag, "_data"}, int'(pm_data), 0);
    checkVal({tag, "_done"}, int'(PMInputDone), 0);
    checkVal({tag, "_err"}, int'(load_error), 0);
    checkVal({tag, "_code"}, int'(error_code), 0);
    checkVal({tag, "_len"}, int'(prog_len), 0);
    checkVal({tag, "_ready"}, int'(char_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #3;
    checkAllZero("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkVal("idleReady", int'(char_ready), 0);

    // "+[-]." then NUL
    startLoad();
    sendStr("+[-].");
    sendChar(8'h00, 1'b1);
    checkVal("doneE1", int'(PMInputDone), 0);
    @(posedge clock);
    #1;
    checkVal("doneE2", int'(PMInputDone), 1);
    checkVal("len5", int'(prog_len), 5);
    checkVal("doneReady", int'(char_ready), 0);
    checkDrained("sbDrain1");

    // Comments plus end_load terminator
    startLoad();
    checkVal("doneCleared", int'(PMInputDone), 0);
    sendStr("a+ b\n>");
    end_load = 1'b1;
    sbQ.push_back('{addr: tbPtr, data: 0});
    @(posedge clock);
    #1;
    end_load = 1'b0;
    @(posedge clock);
    #1;
    checkVal("endLoadDone", int'(PMInputDone), 1);
    checkVal("len2", int'(prog_len), 2);
    checkDrained("sbDrain2");

    // Unmatched ']'
    startLoad();
`ifdef BF_LOADER_CHECK_EN
    sendChar("]", 1'b0);
    checkVal("underErr", int'(load_error), 1);
    checkVal("underCode", int'(error_code), 1);
    checkVal("underReady", int'(char_ready), 0);
`else
    sendChar("]", 1'b1);
    sendChar(8'h00, 1'b1);
    @(posedge clock);
    #1;
    checkVal("closeDone", int'(PMInputDone), 1);
    checkVal("closeCode", int'(error_code), 0);
`endif
    checkDrained("sbDrain3");

    // Unbalanced "[["
    startLoad();
    sendStr("[[");
`ifdef BF_LOADER_CHECK_EN
    sendChar(8'h00, 1'b0);
    checkVal("unbalErr", int'(load_error), 1);
    checkVal("unbalCode", int'(error_code), 2);
    @(posedge clock);
    #1;
    checkVal("unbalDone", int'(PMInputDone), 0);
`else
    sendChar(8'h00, 1'b1);
    @(posedge clock);
    #1;
    checkVal("openDone", int'(PMInputDone), 1);
    checkVal("openErr", int'(load_error), 0);
`endif
    checkDrained("sbDrain4");

    // Memory exactly filled, HALT in the last word
    startLoad();
    for (int i = 0; i < CAP; i++) sendChar("+", 1'b1);
    sendChar(8'h00, 1'b1);
    @(posedge clock);
    #1;
    checkVal("fullDone", int'(PMInputDone), 1);
    checkVal("fullLen", int'(prog_len), CAP);
    checkDrained("sbDrain5");

    // One command too many
    startLoad();
    for (int i = 0; i < CAP; i++) sendChar("+", 1'b1);
    sendChar("+", 1'b0);
    checkVal("ovfErr", int'(load_error), 1);
    checkVal("ovfCode", int'(error_code), 3);
    checkVal("ovfLen", int'(prog_len), CAP);
    checkVal("ovfReady", int'(char_ready), 0);
    checkDrained("sbDrain6");

    // Reset mid-stream, then a fresh load
    startLoad();
    sendStr("+>");
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkAllZero("midReset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    checkVal("sbAfterReset", sbQ.size(), 0);
    @(posedge clock);
    #1;
    startLoad();
    sendChar(".", 1'b1);
    sendChar(8'h00, 1'b1);
    @(posedge clock);
    #1;
    checkVal("reloadDone", int'(PMInputDone), 1);
    checkVal("reloadLen", int'(prog_len), 1);
    checkDrained("sbDrain7");

    // end_load and char_valid together: character left unconsumed
    startLoad();
    sendChar("+", 1'b1);
    char_in    = "-";
    char_valid = 1'b1;
    end_load   = 1'b1;
    @(negedge clock);
    checkVal("bothReady", int'(char_ready), 0);
    sbQ.push_back('{addr: tbPtr, data: 0});
    @(posedge clock);
    #1;
    end_load = 1'b0;
    @(posedge clock);
    #1;
    char_valid = 1'b0;
    checkVal("bothDone", int'(PMInputDone), 1);
    checkVal("bothLen", int'(prog_len), 1);
    checkDrained("sbDrain8");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
